// File: rtl/mem_arbiter.sv
// Shares one single-port, fixed-latency memory between instruction fetch (IF) and load/store (LS).
// LS has priority, bounded by a streak limit. `define MEM_ARB_PERF_CNT_EN adds grant and stall counters.
module mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 2,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [DATA_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  input  logic [3:0]            ls_byte_en_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_byte_en_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_if_grants_o,
  output logic [31:0]           perf_ls_grants_o,
  output logic [31:0]           perf_if_stall_o
`endif
);

  localparam int SW = $clog2(MAX_LS_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic [3:0]            lat_cnt, lat_cnt_next;
  logic [SW-1:0]         streak, streak_next;
  logic                  arb, grant_ls, grant_if;

  logic                  req_ls;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [3:0]            req_be;

  logic [DATA_WIDTH-1:0] resp_data;
  logic [DATA_WIDTH-1:0] if_rdata_q, ls_rdata_q;

  always_comb begin
    arb      = (state == IDLE) || (state == RESP);
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (arb) begin
      if (ls_req_i && !((streak == SW'(MAX_LS_STREAK)) && if_req_i)) grant_ls = 1'b1;
      else if (if_req_i)                                              grant_if = 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    lat_cnt_next = lat_cnt;
    streak_next  = streak;
    case (state)
      IDLE, RESP: state_next = (grant_ls || grant_if) ? ISSUE : IDLE;
      ISSUE: begin
        lat_cnt_next = 4'(MEM_LATENCY - 1);
        state_next   = (MEM_LATENCY > 1) ? WAIT : RESP;
      end
      WAIT: begin
        lat_cnt_next = lat_cnt - 4'd1;
        if (lat_cnt == 4'd1) state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
    // An absent fetch request also resets the streak, so LS alone never builds one up.
    if (arb) begin
      if (!if_req_i || grant_if) streak_next = '0;
      else if (grant_ls)         streak_next = streak + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      streak     <= '0;
      req_ls     <= 1'b0;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_be     <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_cnt_next;
      streak  <= streak_next;
      if (grant_ls || grant_if) begin
        req_ls    <= grant_ls;
        req_we    <= grant_ls & ls_we_i;
        req_addr  <= grant_ls ? ls_addr_i : if_addr_i;
        req_wdata <= grant_ls ? ls_wdata_i : '0;
        req_be    <= grant_ls ? ls_byte_en_i : 4'b0000;
      end
      if (state == RESP) begin
        if (req_ls) ls_rdata_q <= resp_data;
        else        if_rdata_q <= resp_data;
      end
    end
  end

  // Memory data arrives in the RESP cycle itself, so it is passed through then and held afterwards.
  always_comb begin
    resp_data     = req_we ? '0 : mem_rdata_i;
    mem_en_o      = (state == ISSUE);
    mem_we_o      = mem_en_o & req_we;
    mem_addr_o    = mem_en_o ? req_addr  : '0;
    mem_wdata_o   = mem_en_o ? req_wdata : '0;
    mem_byte_en_o = mem_en_o ? req_be    : 4'b0000;
    if_gnt_o      = mem_en_o & ~req_ls;
    ls_gnt_o      = mem_en_o &  req_ls;
    if_rvalid_o   = (state == RESP) & ~req_ls;
    ls_rvalid_o   = (state == RESP) &  req_ls;
    if_rdata_o    = if_rvalid_o ? resp_data : if_rdata_q;
    ls_rdata_o    = ls_rvalid_o ? resp_data : ls_rdata_q;
    busy_o        = (state != IDLE);
  end

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_grants_o <= '0;
      perf_ls_grants_o <= '0;
      perf_if_stall_o  <= '0;
    end else begin
      if (if_gnt_o)              perf_if_grants_o <= perf_if_grants_o + 32'd1;
      if (ls_gnt_o)              perf_ls_grants_o <= perf_ls_grants_o + 32'd1;
      if (if_req_i && !if_gnt_o) perf_if_stall_o  <= perf_if_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level arbitration model predicts every issue
// and response; a monitor compares them against the DUT as they appear.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [DW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req = 1'b0, ls_we = 1'b0;
  logic [DW-1:0] ls_addr = '0, ls_wdata = '0;
  logic [3:0]    ls_be = '0;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_en, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]   perf_ifg, perf_lsg, perf_stall;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(LAT), .MAX_LS_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_byte_en_i(ls_be), .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_byte_en_o(mem_be), .mem_rdata_i(mem_rdata), .busy_o(busy)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_if_grants_o(perf_ifg), .perf_ls_grants_o(perf_lsg), .perf_if_stall_o(perf_stall)
`endif
  );

  typedef struct {int cyc; bit ls; logic we; logic [DW-1:0] addr; logic [DW-1:0] wdata; logic [3:0] be;} iss_t;
  typedef struct {int cyc; bit ls; logic [DW-1:0] data;} resp_t;
  typedef struct {int cyc; logic [DW-1:0] addr;} rd_t;

  iss_t  exp_iss_q[$];
  resp_t exp_resp_q[$];
  rd_t   rd_q[$];
  bit    gnt_log[$];
  int    gnt_cyc_log[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  bit log_en = 1'b0;

  // reference model state
  bit in_flight = 1'b0, iss_ls = 1'b0, exp_busy = 1'b0;
  int resp_cyc = -1, iss_cyc = -1, streak = 0;
  int exp_ifg = 0, exp_lsg = 0, exp_stall = 0;

  function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
    if (a == 32'h0000_0010) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Arbitration model: at each decision point the spec rules pick a winner and the
  // issue (next cycle) and response (LAT cycles later) are predicted.
  always @(posedge clk) begin
    iss_t  e;
    resp_t r;
    bit    ls_win;
    if (rst) begin
      exp_iss_q.delete();
      exp_resp_q.delete();
      in_flight = 1'b0; streak = 0; exp_busy = 1'b0; iss_cyc = -1; resp_cyc = -1;
      exp_ifg = 0; exp_lsg = 0; exp_stall = 0;
    end else begin
      if (if_req && !(iss_cyc == cyc && !iss_ls)) exp_stall++;
      if (iss_cyc == cyc) begin
        if (iss_ls) exp_lsg++;
        else        exp_ifg++;
      end
      if (!in_flight || cyc == resp_cyc) begin
        in_flight = 1'b0;
        if (if_req || ls_req) begin
          ls_win  = ls_req && !(streak == MAXS && if_req);
          e.cyc   = cyc + 1;
          e.ls    = ls_win;
          e.we    = ls_win ? ls_we : 1'b0;
          e.addr  = ls_win ? ls_addr : if_addr;
          e.wdata = ls_win ? ls_wdata : '0;
          e.be    = ls_win ? ls_be : 4'b0000;
          r.cyc   = cyc + 1 + LAT;
          r.ls    = ls_win;
          r.data  = (ls_win && ls_we) ? '0 : mem_word(e.addr);
          exp_iss_q.push_back(e);
          exp_resp_q.push_back(r);
          in_flight = 1'b1; iss_cyc = cyc + 1; resp_cyc = cyc + 1 + LAT; iss_ls = ls_win;
          if (!if_req || !ls_win) streak = 0;
          else                    streak++;
        end else begin
          streak = 0;
        end
      end
      exp_busy = in_flight;
    end
    cyc++;
  end

  // Memory: read data is valid exactly LAT cycles after the issue cycle, noise otherwise.
  always @(negedge clk) begin
    rd_t d;
    if (mem_en && !mem_we) begin
      d.cyc = cyc + LAT; d.addr = mem_addr;
      rd_q.push_back(d);
    end
  end

  always @(posedge clk) begin
    #1;
    while (rd_q.size() > 0 && rd_q[0].cyc < cyc) void'(rd_q.pop_front());
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) mem_rdata = mem_word(rd_q.pop_front().addr);
    else                                        mem_rdata = $urandom;
  end

  // Monitor
  always @(negedge clk) begin
    iss_t  e;
    resp_t r;
    while (exp_iss_q.size() > 0 && exp_iss_q[0].cyc < cyc) begin
      check("issue_missed_at_cycle", cyc, exp_iss_q[0].cyc);
      void'(exp_iss_q.pop_front());
    end
    while (exp_resp_q.size() > 0 && exp_resp_q[0].cyc < cyc) begin
      check("resp_missed_at_cycle", cyc, exp_resp_q[0].cyc);
      void'(exp_resp_q.pop_front());
    end
    if (mem_en) begin
      if (exp_iss_q.size() == 0) check("unexpected_issue", mem_en, 1'b0);
      else begin
        e = exp_iss_q.pop_front();
        check("issue_cycle", cyc, e.cyc);
        check("issue_ls_gnt", ls_gnt, e.ls);
        check("issue_if_gnt", if_gnt, !e.ls);
        check("issue_addr", mem_addr, e.addr);
        check("issue_we", mem_we, e.we);
        check("issue_wdata", mem_wdata, e.wdata);
        check("issue_be", mem_be, e.be);
        if (log_en) begin
          gnt_log.push_back(ls_gnt);
          gnt_cyc_log.push_back(cyc);
        end
      end
    end else if (if_gnt || ls_gnt) begin
      check("gnt_without_mem_en", {if_gnt, ls_gnt}, 2'b00);
    end
    if (if_rvalid || ls_rvalid) begin
      if (exp_resp_q.size() == 0) check("unexpected_rvalid", {if_rvalid, ls_rvalid}, 2'b00);
      else begin
        r = exp_resp_q.pop_front();
        check("resp_cycle", cyc, r.cyc);
        check("resp_ls_rvalid", ls_rvalid, r.ls);
        check("resp_if_rvalid", if_rvalid, !r.ls);
        check("resp_rdata", r.ls ? ls_rdata : if_rdata, r.data);
      end
    end
    check("busy", busy, exp_busy);
  end

  task automatic cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic if_access(input logic [DW-1:0] a);
    int t = 0;
    if_req = 1'b1; if_addr = a;
    do begin @(negedge clk); t++; end while (!if_gnt && t < 200);
    if (!if_gnt) check("if_gnt_timeout", if_gnt, 1'b1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic ls_access(input logic we, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                           input logic [3:0] be);
    int t = 0;
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd; ls_be = be;
    do begin @(negedge clk); t++; end while (!ls_gnt && t < 200);
    if (!ls_gnt) check("ls_gnt_timeout", ls_gnt, 1'b1);
    @(posedge clk); #1;
    ls_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_gnt"}, if_gnt, 1'b0);
    check({tag, "_ls_gnt"}, ls_gnt, 1'b0);
    check({tag, "_if_rvalid"}, if_rvalid, 1'b0);
    check({tag, "_ls_rvalid"}, ls_rvalid, 1'b0);
    check({tag, "_mem_en"}, mem_en, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, '0);
    check({tag, "_mem_wdata"}, mem_wdata, '0);
    check({tag, "_mem_be"}, mem_be, 4'b0000);
    check({tag, "_if_rdata"}, if_rdata, '0);
    check({tag, "_ls_rdata"}, ls_rdata, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    // single fetch, then the data must hold after the response
    if_access(32'h0000_0010);
    cycles(LAT + 2);
    @(negedge clk);
    check("if_rdata_hold", if_rdata, 32'h0050_0093);
    @(posedge clk); #1;

    // single store
    ls_access(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011);
    cycles(LAT + 2);

    // both requesting continuously: streak limit gives LS x4 then IF
    log_en = 1'b1;
    fork
      repeat (3)  if_access({$urandom_range(0, 16'hFFFF), 2'b00});
      repeat (12) ls_access(1'b0, {$urandom_range(0, 16'hFFFF), 2'b00}, $urandom, 4'hF);
    join
    cycles(LAT + 3);
    log_en = 1'b0;
    check("stream_grant_count", gnt_log.size(), 15);
    for (int i = 0; i < gnt_log.size(); i++) begin
      check($sformatf("stream_grant_%0d_is_ls", i), gnt_log[i], (i % 5) != 4);
      if (i > 0) check($sformatf("stream_gnt_spacing_%0d", i), gnt_cyc_log[i] - gnt_cyc_log[i-1], LAT + 1);
    end

    // reset while a fetch is waiting on memory
    if_req = 1'b1; if_addr = 32'h0000_0200; t = 0;
    do begin @(negedge clk); t++; end while (!if_gnt && t < 200);
    if (!if_gnt) check("rst_test_gnt_timeout", if_gnt, 1'b1);
    @(posedge clk); #1;
    if_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_rst");
    @(posedge clk); #1;
    cycles(LAT + 3);
    if_access(32'h0000_0300);
    cycles(LAT + 2);

    // randomized mixed traffic
    fork
      repeat (30) begin
        cycles($urandom_range(0, 3));
        if_access({$urandom_range(0, 16'hFFFF), 2'b00});
      end
      repeat (40) begin
        cycles($urandom_range(0, 2));
        ls_access(1'($urandom_range(0, 1)), {$urandom_range(0, 16'hFFFF), 2'b00}, $urandom,
                  4'($urandom_range(0, 15)));
      end
    join
    cycles(LAT + 4);

    @(negedge clk);
    check("iss_q_drained", exp_iss_q.size(), 0);
    check("resp_q_drained", exp_resp_q.size(), 0);
`ifdef MEM_ARB_PERF_CNT_EN
    check("perf_if_grants", perf_ifg, exp_ifg);
    check("perf_ls_grants", perf_lsg, exp_lsg);
    check("perf_if_stall", perf_stall, exp_stall);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single shared memory port between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the fetch path and the load/store path on one side, and a unified single-port memory with fixed read latency on the other.
- Arbitration is fixed-priority in favour of LS, with a streak limit that prevents IF starvation.
- Owns request latching, memory issue, latency counting and response routing.

Parameters:
- DATA_WIDTH, 32, data and address width.
- MEM_LATENCY, 2, cycles from memory issue to valid mem_rdata_i; legal range 1..15.
- MAX_LS_STREAK, 4, maximum consecutive LS grants while if_req_i is pending; legal range >=1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- if_req_i  input  1  fetch request; held with address until if_gnt_o.
- if_addr_i  input  DATA_WIDTH  fetch address.
- if_gnt_o  output  1  one-cycle pulse; fetch request accepted and issued.
- if_rvalid_o  output  1  one-cycle pulse; if_rdata_o valid.
- if_rdata_o  output  DATA_WIDTH  fetched instruction word.
- ls_req_i  input  1  load/store request; held with all ls_* inputs until ls_gnt_o.
- ls_we_i  input  1  1 = store, 0 = load.
- ls_addr_i  input  DATA_WIDTH  load/store address.
- ls_wdata_i  input  DATA_WIDTH  store data.
- ls_byte_en_i  input  4  store byte enables.
- ls_gnt_o  output  1  one-cycle pulse; LS request issued.
- ls_rvalid_o  output  1  one-cycle pulse; load data valid, or store complete.
- ls_rdata_o  output  DATA_WIDTH  load data; 0 for stores.
- mem_en_o  output  1  memory access strobe (single cycle).
- mem_we_o  output  1  memory write enable; qualified by mem_en_o.
- mem_addr_o  output  DATA_WIDTH  memory address.
- mem_wdata_o  output  DATA_WIDTH  memory write data.
- mem_byte_en_o  output  4  memory byte enables.
- mem_rdata_i  input  DATA_WIDTH  memory read data; valid MEM_LATENCY cycles after the mem_en_o cycle.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- States and transitions:
  - IDLE: if any request is pending, arbitrate → ISSUE; otherwise stay.
  - ISSUE: → WAIT.
  - WAIT: → RESP when the counter reaches 0.
  - RESP: if a request is pending, arbitrate → ISSUE; otherwise → IDLE.
- Arbitration happens only in IDLE and RESP:
  - Winner = LS if ls_req_i, unless streak == MAX_LS_STREAK and if_req_i is high; then IF wins.
  - The winner's request fields are registered into an internal request latch, together with an owner bit.
- Streak counter:
  - Increments on each LS grant.
  - Clears on each IF grant.
  - Clears when if_req_i is low at arbitration time.
- ISSUE cycle:
  - mem_en_o = 1; mem_* driven from the latch.
  - Owner's gnt_o = 1.
  - Latency counter loads MEM_LATENCY-1.
- WAIT: counter decrements each cycle; mem_en_o = 0.
- RESP cycle:
  - Owner's rvalid_o = 1.
  - rdata_o = mem_rdata_i for loads and fetches; 0 for stores.
- Latency rule: a grant decided at cycle T produces gnt at T+1 and rvalid at T+1+MEM_LATENCY.
- Back-to-back transactions: a new ISSUE can occur the cycle after RESP. Peak throughput is 1 access per MEM_LATENCY+1 cycles.
- Requesters drop req the cycle after gnt unless they want a further access. A req still high at RESP is treated as a new request.
- mem_we_o, mem_byte_en_o, mem_wdata_o are forced to 0 for IF transactions.
- Simultaneous requests at streak < MAX_LS_STREAK → LS wins; IF waits with if_req_i held.
- rdata_o outputs are registered and hold their last value outside RESP; rvalid is the only qualifier.
- Reset values (from rst at any time, including mid-transaction):
  - State IDLE; latch, counter and streak cleared.
  - All *_gnt_o, *_rvalid_o, mem_en_o, mem_we_o, busy_o = 0.
  - rdata and mem_* buses = 0.
  - An in-flight transaction is discarded: no rvalid is ever produced for it.
  - Requests are not sampled in the cycle rst is high.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, three extra output ports are added, each 32-bit, cleared by rst, wrapping at 2^32:
  - perf_if_grants_o: count of if_gnt_o pulses.
  - perf_ls_grants_o: count of ls_gnt_o pulses.
  - perf_if_stall_o: cycles with if_req_i high and if_gnt_o low.
- When not defined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- MEM_LATENCY=2, single IF request at addr 0x0000_0010 with mem returning 0x0050_0093 → if_gnt_o at T+1, mem_addr_o=0x10 with mem_en_o=1 at T+1, if_rvalid_o at T+3 with if_rdata_o=0x0050_0093, busy_o high T+1..T+3.
- LS store addr 0x100, wdata 0xDEAD_BEEF, byte_en 4'b0011 → mem_we_o=1 and mem_byte_en_o=0011 on the issue cycle; ls_rvalid_o pulses with ls_rdata_o=0; no if_* activity.
- IF and LS both requesting continuously, MAX_LS_STREAK=4 → grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF…; IF is never starved.
- Back-to-back LS loads, MEM_LATENCY=1 → successive ls_gnt_o pulses exactly 2 cycles apart; each ls_rvalid_o carries the matching mem_rdata_i.
- rst asserted during WAIT of an IF fetch → no if_rvalid_o afterwards; all outputs 0 the cycle after rst; a fresh request issues normally after rst deasserts.
- With MEM_ARB_PERF_CNT_EN: 3 IF grants, 5 LS grants, and 7 IF-stalled cycles → perf_if_grants_o=3, perf_ls_grants_o=5, perf_if_stall_o=7.
